// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration between the instruction
// fetch port (m0) and the load/store port (m1), APB SETUP/ACCESS sequencing,
// and a watchdog that force-completes ACCESS phases with an error when the
// slave never raises pready.
//
// Requester handshake: a requester raises reqN with addr/wdata/write/stb and
// keeps it high until ackN pulses for one cycle; the completion status
// (errN, and rdataN on reads) is valid in that same cycle and is held until
// that master's next completion. A request withdrawn after its grant is still
// carried through to completion and acknowledged.
module apb_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  APB_PCLK,
    input  logic                  APB_PRESETn,
    // master 0 (instruction fetch)
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_write,
    input  logic [3:0]            m0_stb,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    // master 1 (load/store)
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_write,
    input  logic [3:0]            m1_stb,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    // APB bus
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr,
    // FSM state for observation: 0 IDLE, 1 SETUP, 2 ACCESS
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Watchdog fires when the counter reaches TIMEOUT_CYCLES-1 in ACCESS,
    // i.e. on the TIMEOUT_CYCLES-th ACCESS cycle without pready.
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      state;
    logic        last_grant;
    logic [15:0] to_cnt;

    logic        grant_m1;
    logic        any_req;
    logic        timeout_hit;
    logic        done;
    logic        done_err;
    logic [DATA_WIDTH-1:0] done_rdata;

    assign dbg_state = state;

    // Arbitration and completion decode: with both requesting, the master
    // that did not win last time goes next; pready beats the watchdog.
    always_comb begin
        any_req     = m0_req | m1_req;
        grant_m1    = m1_req & (~m0_req | ~last_grant);
        timeout_hit = TO_EN && (to_cnt == TO_LAST);
        done        = pready | timeout_hit;
        done_err    = pready ? perr : 1'b1;
        done_rdata  = pready ? prdata : '0;
    end

    // Bus sequencer: grant in IDLE (skipped during the ack turnaround cycle),
    // SETUP for one cycle, ACCESS until pready or watchdog expiry.
    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            to_cnt     <= 16'd0;
            paddr      <= '0;
            pdata      <= '0;
            pwrite     <= 1'b0;
            pstb       <= 4'd0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!m0_ack && !m1_ack && any_req) begin
                        last_grant <= grant_m1;
                        paddr      <= grant_m1 ? m1_addr  : m0_addr;
                        pdata      <= grant_m1 ? m1_wdata : m0_wdata;
                        pwrite     <= grant_m1 ? m1_write : m0_write;
                        pstb       <= grant_m1 ? m1_stb   : m0_stb;
                        psel       <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    to_cnt  <= 16'd0;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= ST_IDLE;
                        if (last_grant) begin
                            m1_ack <= 1'b1;
                            m1_err <= done_err;
                            if (!pwrite) m1_rdata <= done_rdata;
                        end else begin
                            m0_ack <= 1'b1;
                            m0_err <= done_err;
                            if (!pwrite) m0_rdata <= done_rdata;
                        end
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (watchdog set to 8 ACCESS cycles).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_apb_master_arbiter;

    logic        APB_PCLK;
    logic        APB_PRESETn;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_write, m1_write;
    logic [3:0]  m0_stb, m1_stb;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] paddr, pdata, prdata;
    logic        pwrite, psel, penable, pready, perr;
    logic [3:0]  pstb;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // expected held completion status per master
    logic [31:0] exp_rd [2];
    logic        exp_er [2];

    apb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .APB_PCLK(APB_PCLK), .APB_PRESETn(APB_PRESETn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
        .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
        .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .perr(perr),
        .dbg_state(dbg_state)
    );

    // clock
    initial APB_PCLK = 1'b0;
    always #5 APB_PCLK = ~APB_PCLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge APB_PCLK);
        @(negedge APB_PCLK);
    endtask

    task automatic check_status(input string tag);
        check_val({tag, " m0_rdata"}, m0_rdata, exp_rd[0]);
        check_val({tag, " m1_rdata"}, m1_rdata, exp_rd[1]);
        check_val({tag, " m0_err"}, {31'd0, m0_err}, {31'd0, exp_er[0]});
        check_val({tag, " m1_err"}, {31'd0, m1_err}, {31'd0, exp_er[1]});
    endtask

    task automatic check_bus(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic w, input logic [3:0] s);
        check_val({tag, " paddr"}, paddr, a);
        check_val({tag, " pdata"}, pdata, d);
        check_val({tag, " pwrite"}, {31'd0, pwrite}, {31'd0, w});
        check_val({tag, " pstb"}, {28'd0, pstb}, {28'd0, s});
    endtask

    // One transfer by master m; the slave answers on the k-th ACCESS edge with
    // pready=rdy (rdy=0 lets the watchdog expire on ACCESS cycle 8, k must be 8).
    task automatic xfer(input string tag, input int m, input logic [31:0] a,
                        input logic [31:0] d, input logic w, input logic [3:0] s,
                        input int k, input logic rdy, input logic [31:0] rd, input logic pe,
                        input logic [31:0] exp_rdata, input logic exp_err);
        if (m == 0) begin
            m0_req = 1; m0_addr = a; m0_wdata = d; m0_write = w; m0_stb = s;
        end else begin
            m1_req = 1; m1_addr = a; m1_wdata = d; m1_write = w; m1_stb = s;
        end
        step();
        check_val({tag, " setup psel"}, {31'd0, psel}, 32'd1);
        check_val({tag, " setup penable"}, {31'd0, penable}, 32'd0);
        check_val({tag, " setup state"}, {30'd0, dbg_state}, 32'd1);
        check_bus({tag, " setup"}, a, d, w, s);
        step();
        check_val({tag, " access penable"}, {31'd0, penable}, 32'd1);
        check_val({tag, " access psel"}, {31'd0, psel}, 32'd1);
        check_val({tag, " access state"}, {30'd0, dbg_state}, 32'd2);
        for (int i = 1; i <= k; i++) begin
            if (i == k) begin
                pready = rdy; prdata = rd; perr = pe;
            end
            step();
            if (i < k) begin
                check_val({tag, " wait acks"}, {30'd0, m1_ack, m0_ack}, 32'd0);
                check_val({tag, " wait penable"}, {31'd0, penable}, 32'd1);
                check_bus({tag, " wait"}, a, d, w, s);
            end
        end
        pready = 0; perr = 0; prdata = 32'h0;
        m0_req = 0; m1_req = 0;
        exp_rd[m] = exp_rdata;
        exp_er[m] = exp_err;
        check_val({tag, " done acks"}, {30'd0, m1_ack, m0_ack}, (m == 0) ? 32'd1 : 32'd2);
        check_val({tag, " done psel/penable"}, {30'd0, psel, penable}, 32'd0);
        check_bus({tag, " done hold"}, a, d, w, s);
        check_status({tag, " done"});
        step();
        check_val({tag, " turnaround acks"}, {30'd0, m1_ack, m0_ack}, 32'd0);
        check_val({tag, " turnaround psel"}, {31'd0, psel}, 32'd0);
    endtask

    initial begin
        APB_PRESETn = 0;
        m0_req = 0; m1_req = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_write = 0; m1_write = 0; m0_stb = 0; m1_stb = 0;
        prdata = 0; pready = 0; perr = 0;
        exp_rd[0] = 0; exp_rd[1] = 0; exp_er[0] = 0; exp_er[1] = 0;
        repeat (2) @(negedge APB_PCLK);

        // reset state
        check_val("reset psel/penable", {30'd0, psel, penable}, 32'd0);
        check_val("reset acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        check_val("reset state", {30'd0, dbg_state}, 32'd0);
        check_bus("reset", 32'h0, 32'h0, 1'b0, 4'h0);
        check_status("reset");
        APB_PRESETn = 1;
        step();

        // contention from reset: both held high, order 0,1,0,1, one idle between
        m0_req = 1; m0_addr = 32'h0000_0100; m0_write = 0; m0_stb = 4'hF;
        m1_req = 1; m1_addr = 32'h0000_0200; m1_write = 0; m1_stb = 4'h3;
        for (int t = 0; t < 4; t++) begin
            step();
            check_val("contention grant addr", paddr, (t % 2 == 0) ? 32'h100 : 32'h200);
            check_val("contention psel", {31'd0, psel}, 32'd1);
            step();
            check_val("contention penable", {31'd0, penable}, 32'd1);
            pready = 1; prdata = 32'h1000 + 32'(t);
            step();
            pready = 0;
            if (t == 3) begin
                m0_req = 0; m1_req = 0;
            end
            check_val("contention ack", {30'd0, m1_ack, m0_ack}, (t % 2 == 0) ? 32'd1 : 32'd2);
            step();
            check_val("contention idle psel", {31'd0, psel}, 32'd0);
        end
        exp_rd[0] = 32'h1002; exp_rd[1] = 32'h1003;
        check_status("contention end");

        // single read by master 1, pready two cycles after penable
        xfer("m1 read", 1, 32'h1100_bff8, 32'h0, 1'b0, 4'hF, 2, 1'b1, 32'h0000_1234, 1'b0,
             32'h0000_1234, 1'b0);
        // write by master 0; read data on the bus must not be captured
        xfer("m0 write", 0, 32'h1100_4000, 32'hDEAD_BEEF, 1'b1, 4'hF, 1, 1'b1, 32'h5555_5555, 1'b0,
             32'h0000_1002, 1'b0);
        // slave error on a master 0 read; master 1 error stays clear
        xfer("m0 slverr", 0, 32'h1100_0020, 32'h0, 1'b0, 4'h1, 3, 1'b1, 32'hBAD0_0BAD, 1'b1,
             32'hBAD0_0BAD, 1'b1);
        // watchdog expiry on a master 1 read
        xfer("m1 timeout", 1, 32'h1100_8000, 32'h0, 1'b0, 4'hF, 8, 1'b0, 32'hFFFF_FFFF, 1'b0,
             32'h0, 1'b1);
        // pready on the same cycle the watchdog would fire
        xfer("m1 late ready", 1, 32'h1100_8004, 32'h0, 1'b0, 4'hF, 8, 1'b1, 32'hCAFE_0001, 1'b0,
             32'hCAFE_0001, 1'b0);

        // reset while penable is high
        m0_req = 1; m0_addr = 32'h1100_0040; m0_write = 0; m0_stb = 4'hF;
        step();
        step();
        check_val("rst mid penable", {31'd0, penable}, 32'd1);
        #1 APB_PRESETn = 0;
        #1;
        check_val("rst mid psel/penable", {30'd0, psel, penable}, 32'd0);
        check_val("rst mid acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        m0_req = 0;
        @(negedge APB_PCLK);
        exp_rd[0] = 0; exp_rd[1] = 0; exp_er[0] = 0; exp_er[1] = 0;
        check_status("rst mid");
        APB_PRESETn = 1;
        step();
        check_val("post rst idle acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        xfer("m0 after reset", 0, 32'h1100_0010, 32'h0, 1'b0, 4'hF, 1, 1'b1, 32'h0000_0077, 1'b0,
             32'h0000_0077, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
